ahb_async_sram_ctrl: RTL and testbench

AHB_ASYNC_SRAM_CTRL -- requirements
Module: ahb_async_sram_ctrl

---
 rtl/ahb_async_sram_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_ahb_async_sram_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_async_sram_ctrl.sv
// rtl/ahb_async_sram_ctrl.sv - AHB-Lite slave driving a 16-bit asynchronous SRAM PHY
// Word transfers are split into two halfword beats; beat 0 is driven straight from the address phase.
module ahb_async_sram_ctrl #(
    parameter int N_SRAM_A  = 18,
    parameter int N_SRAM_DQ = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ahbls_hready,
    output logic                ahbls_hready_resp,
    output logic                ahbls_hresp,
    input  logic [31:0]         ahbls_haddr,
    input  logic                ahbls_hwrite,
    input  logic [1:0]          ahbls_htrans,
    input  logic [2:0]          ahbls_hsize,
    input  logic [31:0]         ahbls_hwdata,
    output logic [31:0]         ahbls_hrdata,
    output logic [N_SRAM_A-1:0] ctrl_addr,
    output logic [15:0]         ctrl_dq_out,
    output logic [15:0]         ctrl_dq_oe,
    input  logic [15:0]         ctrl_dq_in,
    output logic                ctrl_ce_n,
    output logic                ctrl_we_n,
    output logic                ctrl_oe_n,
    output logic [1:0]          ctrl_byte_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W1,
        S_R1,
        S_R2,
        S_R3
    } state_t;

    state_t                state_q, state_d;
    logic [N_SRAM_A-1:0]   addr_q, addr_d;
    logic [N_SRAM_DQ-1:0]  dq_q, dq_d;
    logic [31:0]           hrdata_q, hrdata_d;
    logic [15:0]           lo_q, lo_d;
    logic                  word_q, word_d;
    logic                  wr_pend_q, wr_pend_d;
    logic                  wr_sel_q, wr_sel_d;
    logic                  rd_pend_q, rd_pend_d;

    logic                  accept;
    logic                  start;
    logic                  is_word;
    logic [N_SRAM_A-1:0]   beat0_addr;
    logic                  unused_bits;

    assign unused_bits = &{1'b0, ahbls_haddr[31:N_SRAM_A+1], ahbls_htrans[0]};
    assign ahbls_hresp = 1'b0;
    assign ctrl_addr   = addr_d;
    assign ctrl_dq_out = dq_d;
    assign ahbls_hrdata = hrdata_d;

    always_comb begin
        // IDLE and R3 are the only cycles in which a data phase completes.
        accept     = (state_q == S_IDLE) || (state_q == S_R3);
        start      = !rst && accept && ahbls_hready && ahbls_htrans[1];
        is_word    = ahbls_hsize[2] | ahbls_hsize[1];
        beat0_addr = is_word ? {ahbls_haddr[N_SRAM_A:2], 1'b0} : ahbls_haddr[N_SRAM_A:1];

        state_d   = state_q;
        addr_d    = addr_q;
        dq_d      = dq_q;
        hrdata_d  = hrdata_q;
        lo_d      = lo_q;
        word_d    = word_q;
        wr_pend_d = 1'b0;
        wr_sel_d  = wr_sel_q;
        rd_pend_d = 1'b0;

        ctrl_ce_n         = 1'b1;
        ctrl_we_n         = 1'b1;
        ctrl_oe_n         = 1'b1;
        ctrl_byte_n       = 2'b11;
        ctrl_dq_oe        = 16'h0000;
        ahbls_hready_resp = accept;

        case (state_q)
            S_IDLE: begin
                if (wr_pend_q) dq_d = wr_sel_q ? ahbls_hwdata[31:16] : ahbls_hwdata[15:0];
                if (rd_pend_q) hrdata_d = {ctrl_dq_in, ctrl_dq_in};
            end
            S_W1: begin
                addr_d      = {addr_q[N_SRAM_A-1:1], 1'b1};
                ctrl_ce_n   = 1'b0;
                ctrl_we_n   = 1'b0;
                ctrl_byte_n = 2'b00;
                ctrl_dq_oe  = 16'hffff;
                dq_d        = ahbls_hwdata[15:0];
                wr_pend_d   = 1'b1;
                wr_sel_d    = 1'b1;
                state_d     = S_IDLE;
            end
            S_R1: begin
                if (word_q) begin
                    addr_d      = {addr_q[N_SRAM_A-1:1], 1'b1};
                    ctrl_ce_n   = 1'b0;
                    ctrl_oe_n   = 1'b0;
                    ctrl_byte_n = 2'b00;
                    state_d     = S_R2;
                end else begin
                    rd_pend_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_R2: begin
                lo_d    = ctrl_dq_in;
                state_d = S_R3;
            end
            S_R3: begin
                hrdata_d = {ctrl_dq_in, lo_q};
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (start) begin
            addr_d    = beat0_addr;
            ctrl_ce_n = 1'b0;
            word_d    = is_word;
            if (ahbls_hsize == 3'd0) ctrl_byte_n = ahbls_haddr[0] ? 2'b01 : 2'b10;
            else                     ctrl_byte_n = 2'b00;
            if (ahbls_hwrite) begin
                ctrl_we_n  = 1'b0;
                ctrl_dq_oe = 16'hffff;
                if (is_word) begin
                    state_d = S_W1;
                end else begin
                    wr_pend_d = 1'b1;
                    wr_sel_d  = ahbls_haddr[1];
                    state_d   = S_IDLE;
                end
            end else begin
                ctrl_oe_n = 1'b0;
                state_d   = S_R1;
            end
        end

        // Reset silences the PHY immediately, including any registered beat 1.
        if (rst) begin
            ctrl_ce_n   = 1'b1;
            ctrl_we_n   = 1'b1;
            ctrl_oe_n   = 1'b1;
            ctrl_byte_n = 2'b11;
            ctrl_dq_oe  = 16'h0000;
            addr_d      = addr_q;
            dq_d        = dq_q;
            hrdata_d    = hrdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            dq_q      <= '0;
            hrdata_q  <= '0;
            lo_q      <= '0;
            word_q    <= 1'b0;
            wr_pend_q <= 1'b0;
            wr_sel_q  <= 1'b0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            dq_q      <= dq_d;
            hrdata_q  <= hrdata_d;
            lo_q      <= lo_d;
            word_q    <= word_d;
            wr_pend_q <= wr_pend_d;
            wr_sel_q  <= wr_sel_d;
            rd_pend_q <= rd_pend_d;
        end
    end

endmodule

// File: tb/tb_ahb_async_sram_ctrl.sv
// tb/tb_ahb_async_sram_ctrl.sv - scoreboard bench for ahb_async_sram_ctrl with a 2-cycle-lag SRAM model
module tb_ahb_async_sram_ctrl;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    localparam int K_STRB = 0;
    localparam int K_ADDR = 1;
    localparam int K_DQ   = 2;
    localparam int K_RDY  = 3;
    localparam int K_RD   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hready_en = 1'b1;
    logic        ahbls_hready;
    logic        ahbls_hready_resp;
    logic        ahbls_hresp;
    logic [31:0] ahbls_haddr = '0;
    logic        ahbls_hwrite = 1'b0;
    logic [1:0]  ahbls_htrans = T_IDLE;
    logic [2:0]  ahbls_hsize = '0;
    logic [31:0] ahbls_hwdata = '0;
    logic [31:0] ahbls_hrdata;
    logic [17:0] ctrl_addr;
    logic [15:0] ctrl_dq_out;
    logic [15:0] ctrl_dq_oe;
    logic [15:0] ctrl_dq_in;
    logic        ctrl_ce_n, ctrl_we_n, ctrl_oe_n;
    logic [1:0]  ctrl_byte_n;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    logic [15:0] mem [0:63];
    logic [17:0] pipe1, pipe2;

    assign ahbls_hready = hready_en & ahbls_hready_resp;
    assign ctrl_dq_in   = mem[pipe2[5:0]];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        pipe1 <= ctrl_addr;
        pipe2 <= pipe1;
    end

    ahb_async_sram_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .ahbls_hready      (ahbls_hready),
        .ahbls_hready_resp (ahbls_hready_resp),
        .ahbls_hresp       (ahbls_hresp),
        .ahbls_haddr       (ahbls_haddr),
        .ahbls_hwrite      (ahbls_hwrite),
        .ahbls_htrans      (ahbls_htrans),
        .ahbls_hsize       (ahbls_hsize),
        .ahbls_hwdata      (ahbls_hwdata),
        .ahbls_hrdata      (ahbls_hrdata),
        .ctrl_addr         (ctrl_addr),
        .ctrl_dq_out       (ctrl_dq_out),
        .ctrl_dq_oe        (ctrl_dq_oe),
        .ctrl_dq_in        (ctrl_dq_in),
        .ctrl_ce_n         (ctrl_ce_n),
        .ctrl_we_n         (ctrl_we_n),
        .ctrl_oe_n         (ctrl_oe_n),
        .ctrl_byte_n       (ctrl_byte_n)
    );

    function automatic string kname(input int k);
        case (k)
            K_STRB:  return "strobes";
            K_ADDR:  return "ctrl_addr";
            K_DQ:    return "ctrl_dq_out";
            K_RDY:   return "hready_resp";
            default: return "hrdata";
        endcase
    endfunction

    function automatic logic [31:0] actual(input int k);
        case (k)
            K_STRB:  return {11'b0, ctrl_ce_n, ctrl_we_n, ctrl_oe_n, ctrl_byte_n, ctrl_dq_oe};
            K_ADDR:  return {14'b0, ctrl_addr};
            K_DQ:    return {16'b0, ctrl_dq_out};
            K_RDY:   return {31'b0, ahbls_hready_resp};
            default: return ahbls_hrdata;
        endcase
    endfunction

    task automatic ex(input int c, input int k, input logic [31:0] v);
        sb.push_back('{c, k, v});
    endtask

    task automatic idle_s(input int c);
        ex(c, K_STRB, {11'b0, 3'b111, 2'b11, 16'h0000});
    endtask

    task automatic wr_s(input int c, input logic [1:0] bn);
        ex(c, K_STRB, {11'b0, 3'b001, bn, 16'hffff});
    endtask

    task automatic rd_s(input int c, input logic [1:0] bn);
        ex(c, K_STRB, {11'b0, 3'b010, bn, 16'h0000});
    endtask

    task automatic bus(input logic [1:0] tr, input logic wr, input logic [31:0] a, input logic [2:0] sz);
        ahbls_htrans = tr;
        ahbls_hwrite = wr;
        ahbls_haddr  = a;
        ahbls_hsize  = sz;
    endtask

    task automatic nxt(output int t);
        @(posedge clk);
        #1;
        t = cyc;
    endtask

    // Monitor: pops every expectation due this cycle, plus per-cycle bus invariants.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                checks++;
                if (sb[i].cyc < cyc) begin
                    errors++;
                    $display("FAIL %s late entry for cyc=%0d at cyc=%0d", kname(sb[i].kind), sb[i].cyc, cyc);
                end else if (actual(sb[i].kind) !== sb[i].val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d actual=%h expected=%h", kname(sb[i].kind), cyc,
                             actual(sb[i].kind), sb[i].val);
                end
                sb.delete(i);
            end
        end
        if (cyc >= 1) begin
            checks++;
            if ((ctrl_oe_n === 1'b0 && (|ctrl_dq_oe) === 1'b1) || ahbls_hresp !== 1'b0) begin
                errors++;
                $display("FAIL bus_rules cyc=%0d actual oe_n=%b dq_oe=%h hresp=%b expected no oe/dq_oe overlap, hresp=0",
                         cyc, ctrl_oe_n, ctrl_dq_oe, ahbls_hresp);
            end
        end
    end

    initial begin
        int t;
        int a;
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        mem[6] = 16'hC0DE;
        mem[8] = 16'h1234;
        mem[9] = 16'h5678;

        // Address phases presented during reset must be ignored.
        bus(T_NONSEQ, 1'b1, 32'h6, 3'd1);
        nxt(t); idle_s(t);
        nxt(t); idle_s(t);
        rst = 1'b0;
        bus(T_IDLE, 1'b0, 32'h0, 3'd0);
        nxt(t);
        idle_s(t); ex(t, K_ADDR, 0); ex(t, K_DQ, 0); ex(t, K_RD, 0); ex(t, K_RDY, 1);

        // Halfword write, then two back-to-back byte writes.
        nxt(a);
        bus(T_NONSEQ, 1'b1, 32'h0000_0006, 3'd1);
        wr_s(a, 2'b00); ex(a, K_ADDR, 3); ex(a, K_RDY, 1);
        nxt(t);
        bus(T_NONSEQ, 1'b1, 32'h0000_0003, 3'd0); ahbls_hwdata = 32'hBEEF_0000;
        wr_s(t, 2'b01); ex(t, K_ADDR, 1); ex(t, K_DQ, 32'hBEEF); ex(t, K_RDY, 1);
        nxt(t);
        bus(T_NONSEQ, 1'b1, 32'h0000_0004, 3'd0); ahbls_hwdata = 32'hAB00_0000;
        wr_s(t, 2'b10); ex(t, K_ADDR, 2); ex(t, K_DQ, 32'hAB00);
        nxt(t);
        bus(T_IDLE, 1'b0, 32'h0, 3'd0); ahbls_hwdata = 32'h0000_00CD;
        idle_s(t); ex(t, K_DQ, 32'h00CD); ex(t, K_ADDR, 2); ex(t, K_RDY, 1);
        nxt(t);
        ahbls_hwdata = 32'hFFFF_FFFF;
        idle_s(t); ex(t, K_DQ, 32'h00CD);

        // Word read at 0x10.
        nxt(a);
        bus(T_NONSEQ, 1'b0, 32'h0000_0010, 3'd2);
        rd_s(a, 2'b00); ex(a, K_ADDR, 8); ex(a, K_RDY, 1);
        nxt(t);
        bus(T_IDLE, 1'b0, 32'h0, 3'd0);
        rd_s(t, 2'b00); ex(t, K_ADDR, 9); ex(t, K_RDY, 0);
        nxt(t); idle_s(t); ex(t, K_RDY, 0);
        nxt(t); idle_s(t); ex(t, K_RDY, 1); ex(t, K_RD, 32'h5678_1234); ex(t, K_ADDR, 9);
        nxt(t); idle_s(t); ex(t, K_RD, 32'h5678_1234);

        // Halfword read through an aliased address (bits above haddr[18] ignored).
        nxt(a);
        bus(T_NONSEQ, 1'b0, 32'h8008_000C, 3'd1);
        rd_s(a, 2'b00); ex(a, K_ADDR, 6); ex(a, K_RDY, 1);
        nxt(t);
        bus(T_IDLE, 1'b0, 32'h0, 3'd0);
        idle_s(t); ex(t, K_RDY, 0);
        nxt(t); idle_s(t); ex(t, K_RDY, 1); ex(t, K_RD, 32'hC0DE_C0DE);

        // Word write followed immediately by a halfword read.
        nxt(a);
        bus(T_NONSEQ, 1'b1, 32'h0000_0020, 3'd2);
        wr_s(a, 2'b00); ex(a, K_ADDR, 32'h10); ex(a, K_RDY, 1);
        nxt(t);
        bus(T_NONSEQ, 1'b0, 32'h0000_0010, 3'd1); ahbls_hwdata = 32'h1111_2222;
        wr_s(t, 2'b00); ex(t, K_ADDR, 32'h11); ex(t, K_DQ, 32'h2222); ex(t, K_RDY, 0);
        nxt(t);
        rd_s(t, 2'b00); ex(t, K_ADDR, 8); ex(t, K_DQ, 32'h1111); ex(t, K_RDY, 1);
        nxt(t);
        bus(T_IDLE, 1'b0, 32'h0, 3'd0); ahbls_hwdata = 32'h0;
        idle_s(t); ex(t, K_RDY, 0); ex(t, K_DQ, 32'h1111);
        nxt(t); idle_s(t); ex(t, K_RDY, 1); ex(t, K_RD, 32'h1234_1234);

        // Word read with a halfword write accepted in its final cycle.
        nxt(a);
        bus(T_NONSEQ, 1'b0, 32'h0000_0012, 3'd2);
        rd_s(a, 2'b00); ex(a, K_ADDR, 8); ex(a, K_RDY, 1);
        nxt(t);
        bus(T_NONSEQ, 1'b1, 32'h0000_0006, 3'd1);
        rd_s(t, 2'b00); ex(t, K_ADDR, 9); ex(t, K_RDY, 0);
        nxt(t); idle_s(t); ex(t, K_RDY, 0);
        nxt(t);
        wr_s(t, 2'b00); ex(t, K_ADDR, 3); ex(t, K_RDY, 1); ex(t, K_RD, 32'h5678_1234);
        nxt(t);
        bus(T_IDLE, 1'b0, 32'h0, 3'd0); ahbls_hwdata = 32'h7777_0000;
        idle_s(t); ex(t, K_DQ, 32'h7777); ex(t, K_RDY, 1);

        // BUSY, and NONSEQ while HREADY is low, must not start anything.
        nxt(t);
        bus(T_BUSY, 1'b1, 32'h0000_0030, 3'd1);
        idle_s(t); ex(t, K_RDY, 1);
        nxt(t);
        bus(T_NONSEQ, 1'b1, 32'h0000_0030, 3'd1); hready_en = 1'b0;
        idle_s(t); ex(t, K_RDY, 1);
        nxt(t);
        hready_en = 1'b1; bus(T_IDLE, 1'b0, 32'h0, 3'd0);
        idle_s(t); ex(t, K_RDY, 1); ex(t, K_ADDR, 3); ex(t, K_DQ, 32'h7777);

        // Reset in the second cycle of a word write abandons beat 1.
        nxt(a);
        bus(T_NONSEQ, 1'b1, 32'h0000_0040, 3'd2);
        wr_s(a, 2'b00); ex(a, K_ADDR, 32'h20);
        nxt(t);
        bus(T_IDLE, 1'b0, 32'h0, 3'd0); rst = 1'b1; ahbls_hwdata = 32'hDEAD_BEEF;
        idle_s(t); ex(t, K_ADDR, 32'h20);
        nxt(t);
        rst = 1'b0;
        idle_s(t); ex(t, K_RDY, 1); ex(t, K_ADDR, 0); ex(t, K_DQ, 0); ex(t, K_RD, 0);
        nxt(t); idle_s(t); ex(t, K_RDY, 1);

        nxt(t);
        nxt(t);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d pending expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
